// File: rtl/scope_pkg.sv
// Shared constants and state encoding for the scope trace display path.
// Scale math assumes 12-bit samples mapped onto a 480-row screen.
package scope_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SCALE_MUL = 15;
  localparam int SCALE_SHR = 7;
  localparam int PIPE_LAT  = 3;
  localparam int GRID_DX   = 64;
  localparam int GRID_DY   = 60;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;
endpackage

// File: rtl/scope_sample_scaler.sv
// Maps a buffer sample to a screen row (y_cur) and keeps the previous column's row (y_prev).
// One registered stage; y_prev restarts on column 0 so no segment joins into the first column.
module scope_sample_scaler
  import scope_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  first_col,
  output logic [9:0]            y_cur,
  output logic [9:0]            y_prev
);

  logic [15:0] prod;
  logic [9:0]  y_new;

  // Full-scale 4095 lands on row 0, zero on the bottom row.
  always_comb begin
    prod  = 16'(rd_data) * 16'(SCALE_MUL);
    y_new = 10'(V_ACTIVE - 1) - 10'(prod >> SCALE_SHR);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      y_cur  <= '0;
      y_prev <= '0;
    end else begin
      y_cur  <= y_new;
      y_prev <= first_col ? y_new : y_cur;
    end
  end

endmodule

// File: rtl/scope_trace_reader.sv
// Reads the sample buffer in step with the raster and draws trace/graticule pixels, latency 3.
// Holds buf_lock from frame start until the pipeline has drained past the last active pixel.
module scope_trace_reader
  import scope_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  video_on,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  capture_done,
  output logic                  buf_lock,
  output logic                  frame_done,
  output logic                  trace_valid,
  output logic                  proto_err,
  output logic                  pixel_on,
  output logic                  grid_on
);

  state_t     state, state_nxt;
  logic [1:0] drain_cnt;
  logic       drain_last;
  logic       frame_start, frame_end;

  logic [9:0] h_d1, h_d2, v_d1, v_d2;
  logic       von_d1, von_d2;
  logic [9:0] y_cur, y_prev;
  logic [9:0] y_lo, y_hi;
  logic       hit, grid_hit;

  always_comb begin
    frame_start = video_on && (hcount == 10'd0) && (vcount == 10'd0);
    frame_end   = video_on && (hcount == 10'(H_ACTIVE - 1)) && (vcount == 10'(V_ACTIVE - 1));
  end

  // Horizontal blanking columns re-read the last entry rather than running off the buffer.
  always_comb begin
    rd_addr = '0;
    if (reset_n) begin
      rd_addr = (hcount > 10'(H_ACTIVE - 1)) ? ADDR_WIDTH'(H_ACTIVE - 1) : ADDR_WIDTH'(hcount);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= BLANK;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (frame_start) state_nxt = ACTIVE;
      ACTIVE:  if (frame_end)   state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'(PIPE_LAT - 1)) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  always_comb begin
    buf_lock   = (state != BLANK);
    drain_last = (state == DRAIN) && (drain_cnt == 2'(PIPE_LAT - 1));
  end

  // A capture completing while the buffer is on screen is a writer protocol violation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      proto_err   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= drain_last;
      if (capture_done) begin
        if (state == BLANK) trace_valid <= 1'b1;
        else                proto_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h_d1   <= '0;
      h_d2   <= '0;
      v_d1   <= '0;
      v_d2   <= '0;
      von_d1 <= 1'b0;
      von_d2 <= 1'b0;
    end else begin
      h_d1   <= hcount;
      h_d2   <= h_d1;
      v_d1   <= vcount;
      v_d2   <= v_d1;
      von_d1 <= video_on;
      von_d2 <= von_d1;
    end
  end

  scope_sample_scaler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_scaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_data  (rd_data),
    .first_col(h_d1 == 10'd0),
    .y_cur    (y_cur),
    .y_prev   (y_prev)
  );

  // Lighting the whole span between neighbouring rows keeps steep edges continuous.
  always_comb begin
    y_lo     = (y_prev < y_cur) ? y_prev : y_cur;
    y_hi     = (y_prev < y_cur) ? y_cur : y_prev;
    hit      = (v_d2 >= y_lo) && (v_d2 <= y_hi);
    grid_hit = ((h_d2 % 10'(GRID_DX)) == 10'd0) || (h_d2 == 10'(H_ACTIVE - 1)) ||
               ((v_d2 % 10'(GRID_DY)) == 10'd0) || (v_d2 == 10'(V_ACTIVE - 1));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_on <= 1'b0;
      grid_on  <= 1'b0;
    end else begin
      pixel_on <= hit && von_d2 && trace_valid && (state != BLANK);
      grid_on  <= von_d2 && grid_hit;
    end
  end

endmodule

// File: tb/tb_scope_trace_reader.sv
// Raster-driven bench for scope_trace_reader: sparse rows per frame, screen-space reference model.
module tb_scope_trace_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount, vcount;
  logic        video_on;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic        capture_done;
  logic        buf_lock, frame_done, trace_valid, proto_err, pixel_on, grid_on;

  always #5 clock = ~clock;

  scope_trace_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .video_on    (video_on),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .capture_done(capture_done),
    .buf_lock    (buf_lock),
    .frame_done  (frame_done),
    .trace_valid (trace_valid),
    .proto_err   (proto_err),
    .pixel_on    (pixel_on),
    .grid_on     (grid_on)
  );

  logic [11:0] mem [0:639];
  always @(posedge clock) rd_data <= mem[rd_addr];

  int n_run = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: lock window, handshake flags, last three raster inputs.
  bit m_lock = 0, m_active = 0, m_tv = 0, m_perr = 0, m_fd = 0;
  int m_unlock_edge = -1;
  int cycle_n = 0;
  int hh[3], hv[3];
  bit hvon[3], hrst[3];
  int pix_cnt, fd_cnt;
  int rows[$];

  function automatic int row_of(input int s);
    return 479 - (s * 15) / 128;
  endfunction

  task automatic cyc(input int h, input int v, input bit von, input bit rst, input bit cap);
    bit ok, pix_e, grid_e, nl;
    int hc, a, b, lo, hi;
    hcount = 10'(h); vcount = 10'(v); video_on = von; reset_n = rst; capture_done = cap;
    #1;
    hc = (h > 639) ? 639 : h;
    check_val("rd_addr", int'(rd_addr), rst ? hc : 0);
    for (int k = 2; k > 0; k--) begin
      hh[k] = hh[k-1]; hv[k] = hv[k-1]; hvon[k] = hvon[k-1]; hrst[k] = hrst[k-1];
    end
    hh[0] = h; hv[0] = v; hvon[0] = von; hrst[0] = rst;
    // Pixel presented two cycles ago: vertical span between its sample row and its left neighbour's.
    ok = hrst[0] && hrst[1] && hrst[2] && hvon[2];
    grid_e = 0;
    pix_e  = 0;
    if (ok) begin
      grid_e = (hh[2] % 64 == 0) || (hh[2] == 639) || (hv[2] % 60 == 0) || (hv[2] == 479);
      a  = row_of(int'(mem[hh[2]]));
      b  = (hh[2] == 0) ? a : row_of(int'(mem[hh[2]-1]));
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      pix_e = m_tv && m_lock && (hv[2] >= lo) && (hv[2] <= hi);
    end
    if (!rst) begin
      m_lock = 0; m_active = 0; m_unlock_edge = -1; m_tv = 0; m_perr = 0; m_fd = 0;
    end else begin
      nl   = m_lock;
      m_fd = (cycle_n == m_unlock_edge);
      if (m_fd) nl = 0;
      if (cap) begin
        if (!m_lock) m_tv = 1;
        else         m_perr = 1;
      end
      if (!m_lock && von && h == 0 && v == 0) begin
        nl = 1; m_active = 1;
      end
      if (m_active && von && h == 639 && v == 479) begin
        m_active = 0; m_unlock_edge = cycle_n + 3;
      end
      m_lock = nl;
    end
    cycle_n++;
    @(posedge clock);
    #1;
    check_val("pixel_on", int'(pixel_on), int'(pix_e));
    check_val("grid_on", int'(grid_on), int'(grid_e));
    check_val("buf_lock", int'(buf_lock), int'(m_lock));
    check_val("frame_done", int'(frame_done), int'(m_fd));
    check_val("trace_valid", int'(trace_valid), int'(m_tv));
    check_val("proto_err", int'(proto_err), int'(m_perr));
    if (pixel_on) pix_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic idle(input int n, input bit cap);
    for (int i = 0; i < n; i++) cyc(700, 500, 0, 1, cap && (i == n / 2));
  endtask

  // Each visited row is a full contiguous scan so the left-neighbour sample is always defined.
  task automatic frame(input int cap_row, input int cap_col, input int rst_row, input int rst_col);
    pix_cnt = 0;
    fd_cnt  = 0;
    foreach (rows[i]) begin
      for (int h = 0; h < 648; h++) begin
        cyc(h, rows[i], h < 640, !(rows[i] == rst_row && h == rst_col),
            rows[i] == cap_row && h == cap_col);
      end
    end
    for (int i = 0; i < 12; i++) cyc(i, 480, 0, 1, 0);
  endtask

  initial begin
    int prev, cr;
    for (int i = 0; i < 640; i++) mem[i] = 12'd0;
    for (int k = 0; k < 3; k++) begin
      hh[k] = 0; hv[k] = 0; hvon[k] = 0; hrst[k] = 0;
    end
    hcount = 10'd500; vcount = 10'd500; video_on = 0; reset_n = 0; capture_done = 0;
    @(posedge clock);
    #1;
    repeat (3) cyc(500, 500, 0, 0, 0);
    idle(6, 0);

    // No capture yet: graticule only, lock still cycles.
    for (int i = 0; i < 640; i++) mem[i] = 12'd2048;
    rows = '{0, 239, 479};
    frame(-1, -1, -1, -1);
    check_val("no_capture_pixels", pix_cnt, 0);
    check_val("frame_done_count_a", fd_cnt, 1);

    // Mid-scale everywhere: one lit row at 239.
    idle(6, 1);
    rows = '{0, 238, 239, 240, 479};
    frame(-1, -1, -1, -1);
    check_val("mid_scale_pixels", pix_cnt, 640);

    // Step 0 -> 4095 -> 0: columns 1 and 2 fully spanned.
    for (int i = 0; i < 640; i++) mem[i] = 12'd0;
    mem[1] = 12'd4095;
    rows = '{0, 1, 240, 478, 479};
    frame(-1, -1, -1, -1);
    check_val("step_pixels", pix_cnt, 648);

    // Capture while locked.
    rows = '{0, 240, 479};
    frame(240, 10, -1, -1);
    check_val("proto_err_sticky", int'(proto_err), 1);
    check_val("trace_valid_kept", int'(trace_valid), 1);
    check_val("frame_done_count_b", fd_cnt, 1);

    // Reset mid-frame: no frame_done, relock on the following frame.
    rows = '{0, 100, 200, 300, 479};
    frame(-1, -1, 200, 50);
    check_val("reset_frame_done", fd_cnt, 0);
    check_val("reset_lock_released", int'(buf_lock), 0);
    rows = '{0, 479};
    frame(-1, -1, -1, -1);
    check_val("relock_frame_done", fd_cnt, 1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 640; i++) mem[i] = 12'($urandom_range(0, 4095));
      idle(8, $urandom_range(0, 3) != 0);
      rows = '{0};
      prev = 0;
      for (int k = 0; k < 4; k++) begin
        prev = $urandom_range(prev + 1, prev + 110);
        rows.push_back(prev);
      end
      rows.push_back(479);
      cr = ($urandom_range(0, 2) == 0) ? rows[1] : -1;
      frame(cr, $urandom_range(0, 639), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
